// File: rtl/cgra_config_loader_if.sv
// Valid/ready stream of packed PE configuration entries feeding the config loader.
// The source drives the master modport and the loader consumes through the slave modport.
interface cgra_config_loader_if #(
  parameter int unsigned ROW_W  = 2,
  parameter int unsigned COL_W  = 2,
  parameter int unsigned IN_W   = 3,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTX_W  = 4
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_last;
  logic [ROW_W-1:0]  cfg_row;
  logic [COL_W-1:0]  cfg_column;
  logic [IN_W-1:0]   cfg_input_1;
  logic [IN_W-1:0]   cfg_input_2;
  logic [OP_W-1:0]   cfg_op;
  logic [DATA_W-1:0] cfg_const;
  logic [CTX_W-1:0]  cfg_index;

  modport master (
    output cfg_valid, cfg_last, cfg_row, cfg_column, cfg_input_1, cfg_input_2, cfg_op,
           cfg_const, cfg_index,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_last, cfg_row, cfg_column, cfg_input_1, cfg_input_2, cfg_op,
           cfg_const, cfg_index,
    output cfg_ready
  );
endinterface

// File: rtl/cgra_config_loader.sv
// Replays a stream of PE config entries onto the CGRA config port, then pulses start_exec,
// times the run for a latched number of cycles and reports done.
module cgra_config_loader #(
  parameter int unsigned PE_ROW_SIZE             = 4,
  parameter int unsigned PE_COLUMN_SIZE          = 4,
  parameter int unsigned PE_ROW_BIT_LENGTH       = 2,
  parameter int unsigned PE_COLUMN_BIT_LENGTH    = 2,
  parameter int unsigned INPUT_NUM_BIT_LENGTH    = 3,
  parameter int unsigned OPERATION_BIT_LENGTH    = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = 4,
  parameter int unsigned RUN_CNT_WIDTH           = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               i_load_req,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] i_load_context_max_id,
  input  logic [RUN_CNT_WIDTH-1:0]           i_load_run_cycles,
  input  logic                               i_abort,
  cgra_config_loader_if.slave                cfg,
  output logic [PE_ROW_BIT_LENGTH-1:0]       o_config_pe_row_index,
  output logic [PE_COLUMN_BIT_LENGTH-1:0]    o_config_pe_column_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    o_config_input_pe_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    o_config_input_pe_index_2,
  output logic [OPERATION_BIT_LENGTH-1:0]    o_config_op,
  output logic [DATA_WIDTH-1:0]              o_config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] o_config_index,
  output logic                               o_write_config_data,
  output logic                               o_start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] o_mapping_context_max_id,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_error,
  output logic [15:0]                        o_entry_count
);

  typedef enum logic [2:0] {StIdle, StLoad, StFlush, StStart, StRun, StDone} state_e;

  state_e                             r_state, w_state_next;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_max_id;
  logic [RUN_CNT_WIDTH-1:0]           r_run_cycles, r_run_cnt;
  logic                               r_write, r_error;
  logic [15:0]                        r_entry_count;
  logic [PE_ROW_BIT_LENGTH-1:0]       r_row;
  logic [PE_COLUMN_BIT_LENGTH-1:0]    r_column;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    r_input_1, r_input_2;
  logic [OPERATION_BIT_LENGTH-1:0]    r_op;
  logic [DATA_WIDTH-1:0]              r_const;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_index;

  logic w_abort, w_load_accept, w_cfg_accept, w_drop;

  assign w_abort       = i_abort && (r_state != StIdle);
  assign w_load_accept = (r_state == StIdle) && i_load_req && !i_abort;
  // Entries are not consumed in an abort cycle.
  assign w_cfg_accept  = cfg.cfg_valid && (r_state == StLoad) && !i_abort;
  assign w_drop        = (32'(cfg.cfg_row) >= PE_ROW_SIZE) ||
                         (32'(cfg.cfg_column) >= PE_COLUMN_SIZE) ||
                         (cfg.cfg_index > r_max_id);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_load_accept) w_state_next = StLoad;
      StLoad:  if (w_cfg_accept && cfg.cfg_last) w_state_next = StFlush;
      StFlush: w_state_next = StStart;
      StStart: w_state_next = (r_run_cycles == '0) ? StDone : StRun;
      StRun:   if (r_run_cnt <= RUN_CNT_WIDTH'(1)) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (w_abort) w_state_next = StIdle;
  end

  always_comb begin
    cfg.cfg_ready       = (r_state == StLoad) && !i_abort;
    o_write_config_data = r_write && !w_abort;
    o_start_exec        = (r_state == StStart) && !w_abort;
    o_done              = (r_state == StDone) && !w_abort;
    o_busy              = (r_state != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_max_id      <= '0;
      r_run_cycles  <= '0;
      r_run_cnt     <= '0;
      r_write       <= 1'b0;
      r_error       <= 1'b0;
      r_entry_count <= '0;
      r_row         <= '0;
      r_column      <= '0;
      r_input_1     <= '0;
      r_input_2     <= '0;
      r_op          <= '0;
      r_const       <= '0;
      r_index       <= '0;
    end else begin
      r_write <= w_cfg_accept && !w_drop;
      if (w_load_accept) begin
        r_max_id      <= i_load_context_max_id;
        r_run_cycles  <= i_load_run_cycles;
        r_error       <= 1'b0;
        r_entry_count <= '0;
      end
      if (w_cfg_accept) begin
        if (w_drop) begin
          r_error <= 1'b1;
        end else begin
          r_row     <= cfg.cfg_row;
          r_column  <= cfg.cfg_column;
          r_input_1 <= cfg.cfg_input_1;
          r_input_2 <= cfg.cfg_input_2;
          r_op      <= cfg.cfg_op;
          r_const   <= cfg.cfg_const;
          r_index   <= cfg.cfg_index;
          if (r_entry_count != 16'hFFFF) r_entry_count <= r_entry_count + 16'd1;
        end
      end
      if (r_state == StStart)    r_run_cnt <= r_run_cycles;
      else if (r_state == StRun) r_run_cnt <= r_run_cnt - RUN_CNT_WIDTH'(1);
    end
  end

  assign o_config_pe_row_index     = r_row;
  assign o_config_pe_column_index  = r_column;
  assign o_config_input_pe_index_1 = r_input_1;
  assign o_config_input_pe_index_2 = r_input_2;
  assign o_config_op               = r_op;
  assign o_config_const_data       = r_const;
  assign o_config_index            = r_index;
  assign o_mapping_context_max_id  = r_max_id;
  assign o_error                   = r_error;
  assign o_entry_count             = r_entry_count;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Randomized bench for cgra_config_loader: a queue-based model predicts which entries are
// written, when, and the start/done timing of each load.
module tb_cgra_config_loader;
  // 3-bit row/column fields so out-of-range PE coordinates can be expressed.
  localparam int RowW = 3, ColW = 3, InW = 3, OpW = 4, DataW = 32, CtxW = 4, RunW = 16;
  localparam int Rows = 4, Cols = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            i_load_req = 1'b0;
  logic [CtxW-1:0] i_load_context_max_id = '0;
  logic [RunW-1:0] i_load_run_cycles = '0;
  logic            i_abort = 1'b0;
  logic [RowW-1:0] o_row;
  logic [ColW-1:0] o_col;
  logic [InW-1:0]  o_in1, o_in2;
  logic [OpW-1:0]  o_op;
  logic [DataW-1:0] o_const;
  logic [CtxW-1:0] o_idx, o_map;
  logic            o_write, o_start, o_busy, o_done, o_error;
  logic [15:0]     o_count;

  always #5 clk = ~clk;

  cgra_config_loader_if #(.ROW_W(RowW), .COL_W(ColW), .IN_W(InW), .OP_W(OpW),
                          .DATA_W(DataW), .CTX_W(CtxW)) cfg_if ();

  cgra_config_loader #(
    .PE_ROW_SIZE(Rows), .PE_COLUMN_SIZE(Cols), .PE_ROW_BIT_LENGTH(RowW),
    .PE_COLUMN_BIT_LENGTH(ColW), .INPUT_NUM_BIT_LENGTH(InW), .OPERATION_BIT_LENGTH(OpW),
    .DATA_WIDTH(DataW), .CONTEXT_SIZE_BIT_LENGTH(CtxW), .RUN_CNT_WIDTH(RunW)
  ) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .i_load_req               (i_load_req),
    .i_load_context_max_id    (i_load_context_max_id),
    .i_load_run_cycles        (i_load_run_cycles),
    .i_abort                  (i_abort),
    .cfg                      (cfg_if.slave),
    .o_config_pe_row_index    (o_row),
    .o_config_pe_column_index (o_col),
    .o_config_input_pe_index_1(o_in1),
    .o_config_input_pe_index_2(o_in2),
    .o_config_op              (o_op),
    .o_config_const_data      (o_const),
    .o_config_index           (o_idx),
    .o_write_config_data      (o_write),
    .o_start_exec             (o_start),
    .o_mapping_context_max_id (o_map),
    .o_busy                   (o_busy),
    .o_done                   (o_done),
    .o_error                  (o_error),
    .o_entry_count            (o_count)
  );

  typedef struct packed {
    logic [RowW-1:0]  row;
    logic [ColW-1:0]  col;
    logic [InW-1:0]   in1;
    logic [InW-1:0]   in2;
    logic [OpW-1:0]   op;
    logic [DataW-1:0] cdata;
    logic [CtxW-1:0]  idx;
  } entry_t;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle.
  entry_t wr_q[$];
  int     wr_cyc_q[$];
  int     start_q[$];
  int     done_q[$];
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_write) begin
        wr_q.push_back({o_row, o_col, o_in1, o_in2, o_op, o_const, o_idx});
        wr_cyc_q.push_back(cyc);
      end
      if (o_start) start_q.push_back(cyc);
      if (o_done) done_q.push_back(cyc);
    end
  end

  entry_t send_q[$];
  int     acc_q[$];

  function automatic entry_t mk(input int row, input int col, input int idx);
    entry_t e;
    e.row   = RowW'(row);
    e.col   = ColW'(col);
    e.in1   = InW'($urandom);
    e.in2   = InW'($urandom);
    e.op    = OpW'($urandom);
    e.cdata = $urandom;
    e.idx   = CtxW'(idx);
    return e;
  endfunction

  task automatic clear_log();
    wr_q.delete(); wr_cyc_q.delete(); start_q.delete(); done_q.delete(); acc_q.delete();
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_load(input logic [CtxW-1:0] max_id, input logic [RunW-1:0] run);
    i_load_req = 1'b1;
    i_load_context_max_id = max_id;
    i_load_run_cycles = run;
    tick(1);
    i_load_req = 1'b0;
  endtask

  task automatic drive_entry(input entry_t e, input logic last);
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_last    = last;
    cfg_if.cfg_row     = e.row;
    cfg_if.cfg_column  = e.col;
    cfg_if.cfg_input_1 = e.in1;
    cfg_if.cfg_input_2 = e.in2;
    cfg_if.cfg_op      = e.op;
    cfg_if.cfg_const   = e.cdata;
    cfg_if.cfg_index   = e.idx;
    acc_q.push_back(cyc);
    tick(1);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
  endtask

  task automatic wait_event(input int which, input int bound, input string tag);
    int n = 0;
    while (((which == 0) ? done_q.size() : start_q.size()) == 0 && n < bound) begin
      tick(1);
      n++;
    end
    if (((which == 0) ? done_q.size() : start_q.size()) == 0)
      check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // gap: 0 = valid every cycle, 1 = idle cycle between alternate entries, 2 = random idles
  task automatic run_case(input string tag, input logic [CtxW-1:0] max_id,
                          input logic [RunW-1:0] run, input int gap);
    entry_t exp_q[$];
    int     exp_cyc[$];
    bit     exp_err = 1'b0;
    int     n;
    clear_log();
    start_load(max_id, run);
    check({tag, "_err_clr"}, 64'(o_error), 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd1);
    check({tag, "_map"}, 64'(o_map), 64'(max_id));
    for (int i = 0; i < send_q.size(); i++) begin
      if (gap == 1 && (i % 2) == 1) tick(1);
      if (gap == 2) tick($urandom_range(0, 2));
      drive_entry(send_q[i], i == send_q.size() - 1);
    end
    wait_event(0, int'(run) + 20, tag);
    tick(1);
    for (int i = 0; i < send_q.size(); i++) begin
      if (int'(send_q[i].row) < Rows && int'(send_q[i].col) < Cols &&
          send_q[i].idx <= max_id) begin
        exp_q.push_back(send_q[i]);
        exp_cyc.push_back(acc_q[i] + 1);
      end else begin
        exp_err = 1'b1;
      end
    end
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_wdata"}, 64'(wr_q[i]), 64'(exp_q[i]));
      check({tag, "_wcyc"}, 64'(wr_cyc_q[i]), 64'(exp_cyc[i]));
    end
    check({tag, "_nstart"}, 64'(start_q.size()), 64'd1);
    check({tag, "_ndone"}, 64'(done_q.size()), 64'd1);
    if (start_q.size() == 1 && done_q.size() == 1) begin
      check({tag, "_runlen"}, 64'(done_q[0] - start_q[0]), 64'(int'(run) + 1));
      if (wr_cyc_q.size() > 0)
        check({tag, "_start_after_wr"}, 64'(start_q[0] > wr_cyc_q[$]), 64'd1);
    end
    check({tag, "_count"}, 64'(o_count), 64'(exp_q.size()));
    check({tag, "_error"}, 64'(o_error), 64'(exp_err));
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
  endtask

  task automatic rand_entries(input int cnt);
    send_q.delete();
    for (int i = 0; i < cnt; i++)
      send_q.push_back(mk($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 7)));
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last = 1'b0;
    cfg_if.cfg_row = '0;
    cfg_if.cfg_column = '0;
    cfg_if.cfg_input_1 = '0;
    cfg_if.cfg_input_2 = '0;
    cfg_if.cfg_op = '0;
    cfg_if.cfg_const = '0;
    cfg_if.cfg_index = '0;
    #2;
    check("reset_outs", 64'({o_busy, o_write, o_start, o_done, o_error, o_count, o_map,
                             cfg_if.cfg_ready, o_idx, o_row, o_col, o_op}), 64'd0);
    check("reset_const", 64'(o_const), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);

    // Directed three-entry load
    send_q.delete();
    send_q.push_back(mk(0, 0, 0));
    send_q.push_back(mk(1, 2, 1));
    send_q.push_back(mk(3, 3, 3));
    run_case("basic", 4'd3, 16'd5, 0);

    // Back-to-back vs gapped streams
    rand_entries(5);
    run_case("b2b", 4'd7, 16'd3, 0);
    rand_entries(5);
    run_case("gap", 4'd7, 16'd2, 1);

    // Drops on row and context index; next load clears error
    send_q.delete();
    send_q.push_back(mk(1, 1, 2));
    send_q.push_back(mk(4, 0, 0));
    send_q.push_back(mk(2, 2, 7));
    send_q.push_back(mk(0, 3, 3));
    run_case("drop", 4'd3, 16'd2, 0);
    send_q.delete();
    send_q.push_back(mk(2, 1, 1));
    run_case("clr", 4'd3, 16'd1, 0);

    // Run-length boundaries
    send_q.delete();
    send_q.push_back(mk(0, 1, 0));
    run_case("run0", 4'd0, 16'd0, 0);
    send_q.delete();
    send_q.push_back(mk(3, 0, 0));
    run_case("run1", 4'd0, 16'd1, 0);

    // Abort during LOAD after two entries
    clear_log();
    start_load(4'd3, 16'd5);
    drive_entry(mk(0, 0, 0), 1'b0);
    drive_entry(mk(1, 1, 1), 1'b0);
    tick(1);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_ready", 64'(cfg_if.cfg_ready), 64'd0);
    check("abort_count", 64'(o_count), 64'd2);
    tick(10);
    check("abort_nstart", 64'(start_q.size()), 64'd0);
    check("abort_nwr", 64'(wr_q.size()), 64'd2);

    // Abort in the strobe cycle masks the strobe but keeps the count
    clear_log();
    start_load(4'd3, 16'd5);
    drive_entry(mk(2, 2, 2), 1'b0);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    check("abort_strobe_nwr", 64'(wr_q.size()), 64'd0);
    check("abort_strobe_count", 64'(o_count), 64'd1);

    // Abort and load_req together in IDLE: nothing latched
    i_abort = 1'b1;
    start_load(4'd9, 16'd4);
    i_abort = 1'b0;
    check("abort_load_busy", 64'(o_busy), 64'd0);
    check("abort_load_map", 64'(o_map), 64'd3);

    // load_req during RUN is ignored
    clear_log();
    start_load(4'd3, 16'd10);
    drive_entry(mk(1, 0, 2), 1'b1);
    wait_event(1, 10, "ignore_start");
    tick(2);
    start_load(4'd7, 16'd2);
    wait_event(0, 30, "ignore");
    check("ignore_map", 64'(o_map), 64'd3);
    if (start_q.size() == 1 && done_q.size() == 1)
      check("ignore_runlen", 64'(done_q[0] - start_q[0]), 64'd11);
    else
      check("ignore_events", 64'(start_q.size() + done_q.size()), 64'd2);
    tick(2);

    // Asynchronous reset during RUN
    clear_log();
    start_load(4'd2, 16'd30);
    drive_entry(mk(1, 1, 1), 1'b1);
    wait_event(1, 10, "rst_start");
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_outs", 64'({o_busy, o_write, o_start, o_done, o_error, o_count, o_map,
                           cfg_if.cfg_ready, o_idx, o_row, o_col, o_op}), 64'd0);
    check("rst_const", 64'(o_const), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(40);
    check("rst_ndone", 64'(done_q.size()), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);

    // Randomized loads
    for (int k = 0; k < 12; k++) begin
      rand_entries($urandom_range(1, 6));
      run_case("rand", CtxW'($urandom_range(0, 7)), RunW'($urandom_range(0, 6)), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
